rob_retire: RTL and testbench

In-order retirement engine for the reorder buffer: the read side of the ROB, complementing the per-entry buffer cells that are written at dispatch and completion. Each cycle it inspects the entry at the head pointer. When that entry is occupied and ready, it pops the entry into a registered commit port toward the register file, clears the cell through the cell's synchronous clear, and advances the head pointer. It also performs whole-ROB flush.

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_dest_decode.sv | 39 +++
 rtl/rob_retire.sv | 121 ++++++++++++
 tb/tb_rob_retire.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB definitions: opcode and register constants plus the retire FSM state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rob_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } rob_retire_state_t;

endpackage

// File: rtl/rob_dest_decode.sv
// Destination decode: maps a retiring instruction word to its register write enable and rd.
// Latency: purely combinational.
// Backpressure: none; the output follows the input word directly.
module rob_dest_decode (
  input  logic [31:0] instr,
  output logic        we,
  output logic [4:0]  rd
);
  import rob_pkg::*;

  logic [4:0] opcode;
  assign opcode = instr[31:27];

  // Opcode to destination mapping; a write to r0 is suppressed
  always_comb begin
    we = 1'b0;
    rd = 5'd0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_LW: begin
        we = 1'b1;
        rd = instr[26:22];
      end
      OP_JAL: begin
        we = 1'b1;
        rd = REG_RA;
      end
      OP_SETX: begin
        we = 1'b1;
        rd = REG_STATUS;
      end
      default: begin
        we = 1'b0;
        rd = 5'd0;
      end
    endcase
    if (rd == 5'd0) we = 1'b0;
  end

endmodule

// File: rtl/rob_retire.sv
// In-order ROB retirement: pops the ready head entry into a registered commit port, clears the cell, and supports whole-ROB flush.
// Latency: head ready at edge N -> commit_valid after edge N+1; cell_clear is combinational in the popping cycle.
// Backpressure: commit_ready low holds the commit register and blocks further pops. ROB_RETIRE_STATS_EN adds retired/stall counters.
module rob_retire #(
  parameter int ENTRIES = 8,
  parameter int PTR_W   = $clog2(ENTRIES)
) (
  input  logic                  clock,
  input  logic                  reset_sync,
  input  logic [32*ENTRIES-1:0] cell_instr,
  input  logic [32*ENTRIES-1:0] cell_val,
  input  logic [ENTRIES-1:0]    cell_ready,
  input  logic [ENTRIES-1:0]    cell_free,
  input  logic                  flush,
  output logic [ENTRIES-1:0]    cell_clear,
  output logic [PTR_W-1:0]      head,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output logic                  commit_we,
  output logic [4:0]            commit_rd,
  output logic [31:0]           commit_data,
  output logic [31:0]           commit_instr
`ifdef ROB_RETIRE_STATS_EN
  ,
  output logic [31:0]           retired_count,
  output logic [31:0]           stall_count
`endif
);
  import rob_pkg::*;

  rob_retire_state_t state, state_nxt;

  logic [31:0] head_instr;
  logic [31:0] head_val;
  logic        head_occ;
  logic        head_rdy;
  logic        pop;
  logic        dec_we;
  logic [4:0]  dec_rd;

  assign head_instr = cell_instr[32*head +: 32];
  assign head_val   = cell_val[32*head +: 32];
  assign head_occ   = !cell_free[head];
  assign head_rdy   = cell_ready[head];

  rob_dest_decode u_dec (
    .instr (head_instr),
    .we    (dec_we),
    .rd    (dec_rd)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset_sync) state <= S_RUN;
    else            state <= state_nxt;
  end

  // Next state, pop decision and per-cell clear pulses
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    cell_clear = '0;
    case (state)
      S_RUN: begin
        if (flush) state_nxt = S_FLUSH;
        else       pop = head_occ && head_rdy && (!commit_valid || commit_ready);
        if (pop) cell_clear[head] = 1'b1;
      end
      S_FLUSH: begin
        cell_clear = '1;
        state_nxt  = flush ? S_FLUSH : S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    // Reset wipes every cell and overrides any pop
    if (reset_sync) begin
      cell_clear = '1;
      pop        = 1'b0;
    end
  end

  // Head pointer: advance on pop, rewind to 0 on flush
  always_ff @(posedge clock) begin
    if (reset_sync)           head <= '0;
    else if (state == S_FLUSH) head <= '0;
    else if (pop)             head <= head + 1'b1;
  end

  // Commit register: load on pop, drop valid once accepted; flush never cancels it
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_rd    <= 5'd0;
      commit_data  <= 32'd0;
      commit_instr <= 32'd0;
    end else if (pop) begin
      commit_valid <= 1'b1;
      commit_we    <= dec_we;
      commit_rd    <= dec_rd;
      commit_data  <= head_val;
      commit_instr <= head_instr;
    end else if (commit_valid && commit_ready) begin
      commit_valid <= 1'b0;
    end
  end

`ifdef ROB_RETIRE_STATS_EN
  // Retire and head-stall counters; survive flush, wrap naturally
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      retired_count <= 32'd0;
      stall_count   <= 32'd0;
    end else begin
      if (pop)                   retired_count <= retired_count + 32'd1;
      if (head_occ && !head_rdy) stall_count   <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;
  localparam int N  = 8;
  localparam int PW = 3;

  logic            clock = 1'b0;
  logic            reset_sync;
  logic [32*N-1:0] cell_instr;
  logic [32*N-1:0] cell_val;
  logic [N-1:0]    cell_ready;
  logic [N-1:0]    cell_free;
  logic            flush;
  logic [N-1:0]    cell_clear;
  logic [PW-1:0]   head;
  logic            commit_valid;
  logic            commit_ready;
  logic            commit_we;
  logic [4:0]      commit_rd;
  logic [31:0]     commit_data;
  logic [31:0]     commit_instr;

  always #5 clock = ~clock;

  rob_retire #(.ENTRIES(N)) dut (
    .clock        (clock),
    .reset_sync   (reset_sync),
    .cell_instr   (cell_instr),
    .cell_val     (cell_val),
    .cell_ready   (cell_ready),
    .cell_free    (cell_free),
    .flush        (flush),
    .cell_clear   (cell_clear),
    .head         (head),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_we    (commit_we),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_instr (commit_instr)
  );

  // Environment: ROB cell contents, plus the reference retirement model
  logic [31:0] m_instr [N];
  logic [31:0] m_val   [N];
  bit          m_rdy   [N];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] data;
  } commit_t;

  commit_t pend[$];     // retired instruction sitting in the commit port
  int      m_head = 0;  // oldest unretired slot
  bit      m_flush = 0; // a flush cycle is due
  int      tail = 0;    // next slot to dispatch into
  int      nvec = 0;
  int      nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural destination of an instruction word
  function automatic void ref_dest(input logic [31:0] ins, output logic we, output logic [4:0] rd);
    bit writes;
    writes = 1'b1;
    case (ins[31:27])
      5'b00000, 5'b00101, 5'b01000: rd = ins[26:22];
      5'b00011: rd = 5'd31;
      5'b10101: rd = 5'd30;
      default: begin
        rd = 5'd0;
        writes = 1'b0;
      end
    endcase
    we = writes && (rd != 5'd0);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      cell_instr[32*i +: 32] = m_instr[i];
      cell_val[32*i +: 32]   = m_val[i];
      cell_ready[i]          = m_rdy[i];
      cell_free[i]           = (m_instr[i] == 32'd0);
    end
  endtask

  task automatic dispatch(input logic [31:0] ins, input logic [31:0] val, input bit rdy);
    m_instr[tail] = ins;
    m_val[tail]   = val;
    m_rdy[tail]   = rdy;
    tail = (tail + 1) % N;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance model and DUT together
  task automatic cycle();
    logic [N-1:0] exp_clr;
    bit           pop;
    bit           was_flush;
    logic         we;
    logic [4:0]   rd;
    commit_t      c;
    drive();
    #1;
    exp_clr = '0;
    pop = 1'b0;
    if (reset_sync || m_flush) exp_clr = '1;
    else if (!flush && m_instr[m_head] != 32'd0 && m_rdy[m_head] &&
             (pend.size() == 0 || commit_ready)) begin
      pop = 1'b1;
      exp_clr[m_head] = 1'b1;
    end
    check("cell_clear", 32'(cell_clear), 32'(exp_clr));
    check("head", 32'(head), 32'(m_head));
    check("commit_valid", 32'(commit_valid), 32'(pend.size() != 0));
    if (pend.size() != 0) begin
      ref_dest(pend[0].instr, we, rd);
      check("commit_instr", commit_instr, pend[0].instr);
      check("commit_data", commit_data, pend[0].data);
      check("commit_we", 32'(commit_we), 32'(we));
      if (we) check("commit_rd", 32'(commit_rd), 32'(rd));
    end
    was_flush = m_flush;
    if (reset_sync) begin
      pend.delete();
      m_head  = 0;
      m_flush = 1'b0;
    end else begin
      if (pend.size() != 0 && commit_ready) void'(pend.pop_front());
      if (pop) begin
        c.instr = m_instr[m_head];
        c.data  = m_val[m_head];
        pend.push_back(c);
        m_head = (m_head + 1) % N;
      end
      if (was_flush) m_head = 0;
      m_flush = flush;
    end
    if (reset_sync || was_flush) tail = 0;
    for (int i = 0; i < N; i++)
      if (exp_clr[i]) begin
        m_instr[i] = 32'd0;
        m_val[i]   = 32'd0;
        m_rdy[i]   = 1'b0;
      end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] ops [7];
    logic [31:0] w;
    ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101, 5'b00111, 5'b11111};
    w = $urandom;
    w[31:27] = ops[$urandom_range(0, 6)];
    w[0] = 1'b1;
    return w;
  endfunction

  initial begin
    int  a_idx;
    bit  done;
    // Reset with every cell occupied and ready
    reset_sync = 1'b1;
    flush = 1'b0;
    commit_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_instr[i] = 32'h0000_0100 + 32'(i);
      m_val[i]   = 32'(i);
      m_rdy[i]   = 1'b1;
    end
    drive();
    @(posedge clock);
    @(negedge clock);
    cycle();
    check("rst_we", 32'(commit_we), 32'd0);
    check("rst_rd", 32'(commit_rd), 32'd0);
    check("rst_data", commit_data, 32'd0);
    check("rst_instr", commit_instr, 32'd0);
    reset_sync = 1'b0;

    // Single addi r5 retire
    dispatch(32'h2940_0007, 32'h7, 1'b1);
    cycle();
    check("addi_valid", 32'(commit_valid), 32'd1);
    check("addi_we", 32'(commit_we), 32'd1);
    check("addi_rd", 32'(commit_rd), 32'd5);
    check("addi_data", commit_data, 32'd7);
    check("addi_head", 32'(head), 32'd1);
    cycle();

    // Eight ready R-type entries with a 3-cycle register-file stall mid-stream
    for (int i = 0; i < N; i++)
      dispatch({5'b00000, 5'(i + 1), 22'($urandom) | 22'd1}, $urandom, 1'b1);
    repeat (3) cycle();
    commit_ready = 1'b0;
    repeat (3) cycle();
    commit_ready = 1'b1;
    repeat (7) cycle();
    check("wrap_head", 32'(head), 32'd1);

    // sw (no write), jal (rd 31), addi to r0 (no write)
    dispatch(32'h38C0_0010, 32'h11, 1'b1);
    dispatch(32'h1840_0000, 32'h22, 1'b1);
    dispatch(32'h2800_0005, 32'h33, 1'b1);
    cycle();
    check("sw_we", 32'(commit_we), 32'd0);
    cycle();
    check("jal_we", 32'(commit_we), 32'd1);
    check("jal_rd", 32'(commit_rd), 32'd31);
    cycle();
    check("addi0_we", 32'(commit_we), 32'd0);
    cycle();

    // Head not ready while the next entry is: nothing retires out of order
    a_idx = tail;
    dispatch(32'h0000_1111, 32'hA, 1'b0);
    dispatch(32'h0000_2222, 32'hB, 1'b1);
    repeat (3) cycle();
    check("stall_valid", 32'(commit_valid), 32'd0);
    m_rdy[a_idx] = 1'b1;
    repeat (3) cycle();

    // Flush while a commit is stalled: commit survives, ROB empties, refill retires
    commit_ready = 1'b0;
    dispatch(32'h2A00_0001, 32'hC0DE, 1'b1);
    dispatch(32'h2A40_0002, 32'hBEEF, 1'b1);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    check("flush_valid", 32'(commit_valid), 32'd1);
    check("flush_head", 32'(head), 32'd0);
    check("flush_instr", commit_instr, 32'h2A00_0001);
    commit_ready = 1'b1;
    dispatch(32'h2980_0003, 32'h55, 1'b1);
    repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_sync   = ($urandom_range(0, 599) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      commit_ready = ($urandom_range(0, 3) != 0);
      if (m_instr[tail] == 32'd0 && $urandom_range(0, 1) == 1)
        dispatch(rand_instr(), $urandom, $urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++)
        if (m_instr[i] != 32'd0 && $urandom_range(0, 2) == 0) m_rdy[i] = 1'b1;
      cycle();
    end

    // Drain with a bounded budget
    reset_sync = 1'b0;
    flush = 1'b0;
    commit_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      for (int i = 0; i < N; i++)
        if (m_instr[i] != 32'd0) m_rdy[i] = 1'b1;
      cycle();
      done = (pend.size() == 0);
      for (int i = 0; i < N; i++)
        if (m_instr[i] != 32'd0) done = 1'b0;
    end
    check("drain_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
